// File: rtl/hive_reg_gpio_irq.sv
// hive_reg_gpio_irq: rbus GPIO bank with per-bit output and direction control,
// set/clear aliases, synchronised and optionally debounced inputs, and sticky
// rise/fall events driving one registered interrupt line.
module hive_reg_gpio_irq #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h40,
    parameter int                SYNC_STAGES = 2,
    parameter int                DB_TICK_W   = 8,
    parameter logic [DATA_W-1:0] OUT_RST     = '0,
    parameter logic [DATA_W-1:0] OE_RST      = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rbus_addr_i,
    input  logic              rbus_wr_i,
    input  logic              rbus_rd_i,
    input  logic [DATA_W-1:0] rbus_wr_data_i,
    output logic [DATA_W-1:0] rbus_rd_data_o,
    input  logic [DATA_W-1:0] gpio_i,
    output logic [DATA_W-1:0] gpio_o,
    output logic [DATA_W-1:0] gpio_oe_o,
    output logic              irq_o
);
    localparam logic [2:0] OFF_OUT     = 3'd0;
    localparam logic [2:0] OFF_SET     = 3'd1;
    localparam logic [2:0] OFF_CLR     = 3'd2;
    localparam logic [2:0] OFF_OE      = 3'd3;
    localparam logic [2:0] OFF_IN      = 3'd4;
    localparam logic [2:0] OFF_RISE_EN = 3'd5;
    localparam logic [2:0] OFF_FALL_EN = 3'd6;
    localparam logic [2:0] OFF_EVT     = 3'd7;

    logic              sel;
    logic [2:0]        off;
    logic              wr_en;

    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] oe_q, oe_d;
    logic [DATA_W-1:0] rise_en_q, rise_en_d;
    logic [DATA_W-1:0] fall_en_q, fall_en_d;
    logic [DATA_W-1:0] evt_q, evt_d;
    logic [DATA_W-1:0] evt_clr;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              irq_q;

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] sy;
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] in_dly_q;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] fall;

    assign sel   = (rbus_addr_i[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign off   = rbus_addr_i[2:0];
    assign wr_en = rbus_wr_i & sel;

    // Input synchroniser chain, one stage per generate iteration.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            // First stage captures the asynchronous pins.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sync_q[gi] <= '0;
                else       sync_q[gi] <= gpio_i;
            end
        end else begin : g_rest
            // Later stages shift the value along the chain.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sync_q[gi] <= '0;
                else       sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign sy = sync_q[SYNC_STAGES-1];

    if (DB_TICK_W > 0) begin : g_db
        logic [DB_TICK_W-1:0] presc_q;
        logic [DATA_W-1:0]    smp_q;
        logic [DATA_W-1:0]    stable;
        logic                 tick;

        assign tick   = &presc_q;
        assign stable = ~(sy ^ smp_q);

        // Free-running prescaler; wraps from all-ones back to zero.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) presc_q <= '0;
            else       presc_q <= presc_q + DB_TICK_W'(1);
        end

        // Sample the synced pins once per tick.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)     smp_q <= '0;
            else if (tick) smp_q <= sy;
        end

        // Accept a bit only when it matched across two consecutive ticks.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)     in_q <= '0;
            else if (tick) in_q <= (in_q & ~stable) | (smp_q & stable);
        end
    end else begin : g_nodb
        // Debounce bypassed: the synced value is the input value.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) in_q <= '0;
            else       in_q <= sy;
        end
    end

    assign rise = in_q & ~in_dly_q & rise_en_q;
    assign fall = ~in_q & in_dly_q & fall_en_q;

    // Register write decode and sticky event update (new events beat clears).
    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        evt_clr   = '0;
        if (wr_en) begin
            case (off)
                OFF_OUT:     out_d     = rbus_wr_data_i;
                OFF_SET:     out_d     = out_q | rbus_wr_data_i;
                OFF_CLR:     out_d     = out_q & ~rbus_wr_data_i;
                OFF_OE:      oe_d      = rbus_wr_data_i;
                OFF_RISE_EN: rise_en_d = rbus_wr_data_i;
                OFF_FALL_EN: fall_en_d = rbus_wr_data_i;
                OFF_EVT:     evt_clr   = rbus_wr_data_i;
                default:     ;
            endcase
        end
        evt_d = (evt_q & ~evt_clr) | rise | fall;
    end

    // Read mux uses current register values, so a same-cycle write is not seen.
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_OUT, OFF_SET, OFF_CLR: rd_mux = out_q;
            OFF_OE:                    rd_mux = oe_q;
            OFF_IN:                    rd_mux = in_q;
            OFF_RISE_EN:               rd_mux = rise_en_q;
            OFF_FALL_EN:               rd_mux = fall_en_q;
            OFF_EVT:                   rd_mux = evt_q;
            default:                   rd_mux = '0;
        endcase
        rd_data_d = (rbus_rd_i && sel) ? rd_mux : '0;
    end

    // State registers for the register bank, edge history, read data and irq.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q     <= OUT_RST;
            oe_q      <= OE_RST;
            rise_en_q <= '0;
            fall_en_q <= '0;
            evt_q     <= '0;
            in_dly_q  <= '0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            evt_q     <= evt_d;
            in_dly_q  <= in_q;
            rd_data_q <= rd_data_d;
            irq_q     <= |evt_q;
        end
    end

    assign gpio_o         = out_q;
    assign gpio_oe_o      = oe_q;
    assign rbus_rd_data_o = rd_data_q;
    assign irq_o          = irq_q;
endmodule

// File: doc/hive_reg_gpio_irq.md
Name: hive_reg_gpio_irq

Overview:
- Parametrised GPIO register bank on the rbus. Provides per-bit output, output-enable and set/clear ports.
- Inputs pass through a synchroniser and an optional tick-based debounce before being sampled.
- Enabled rising/falling edges are latched into sticky event bits, which drive a single registered interrupt line to the core.
- Replaces single-register GPIO wherever pins need direction control or interrupt-driven input.

Parameters:
- DATA_W, 32, GPIO channel count and rbus data width (1..32).
- ADDR_W, 8, rbus address width.
- BASE_ADDR, 'h40, base of the 8-word register window; must be 8-aligned.
- SYNC_STAGES, 2, input synchroniser flops per bit (>=2).
- DB_TICK_W, 8, debounce prescaler width. A tick fires every 2^DB_TICK_W clocks. 0 = debounce bypassed.
- OUT_RST, 0, reset value of OUT.
- OE_RST, 0, reset value of OE.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- rbus_addr_i  in  ADDR_W  rbus address.
- rbus_wr_i  in  1  write enable, active high.
- rbus_rd_i  in  1  read enable, active high.
- rbus_wr_data_i  in  DATA_W  write data.
- rbus_rd_data_o  out  DATA_W  read data. Registered; zero when not selected.
- gpio_i  in  DATA_W  asynchronous pin inputs.
- gpio_o  out  DATA_W  output values (= OUT).
- gpio_oe_o  out  DATA_W  per-bit output enable (= OE).
- irq_o  out  1  interrupt, active high, registered.

Behaviour:
- Decode: selected when rbus_addr_i[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]. Offset = rbus_addr_i[2:0].
- Register map by offset:
  - 0 OUT: RW.
  - 1 OUT_SET: W1S into OUT; reads OUT.
  - 2 OUT_CLR: W1C into OUT; reads OUT.
  - 3 OE: RW.
  - 4 IN: RO, debounced input; writes ignored.
  - 5 RISE_EN: RW.
  - 6 FALL_EN: RW.
  - 7 EVT: W1C sticky events.
- Writes take effect at the clock edge where rbus_wr_i is high. gpio_o and gpio_oe_o reflect the new value the next cycle.
- Reads: if rbus_rd_i is high and the block is selected, rbus_rd_data_o = register value on the following cycle (1-cycle latency). Otherwise it is 0 that cycle, so outputs can be OR-merged.
- Simultaneous rd+wr to the same register: read returns the pre-write value.
- Sync: gpio_i passes through SYNC_STAGES flops per bit, giving a synced value (sy).
- Debounce (DB_TICK_W>0):
  - Free-running prescaler counter; tick when the counter reaches all-ones, then wrap to 0.
  - On each tick, sample sy into smp.
  - IN[i] <= smp[i] only on a tick where sy[i] == smp[i], i.e. stable across two consecutive ticks.
- Debounce bypass (DB_TICK_W=0): IN <= sy every clock.
- Edge detect, computed from IN and its 1-cycle delayed copy IN_d:
  - rise = IN & ~IN_d & RISE_EN.
  - fall = ~IN & IN_d & FALL_EN.
- EVT update: EVT <= (EVT & ~clr) | rise | fall, where clr = write data on an offset-7 write, else 0. A new event in the same cycle as its W1C clear stays set (set wins).
- irq_o <= |EVT, i.e. asserts 1 cycle after any EVT bit sets.
- Disabling RISE_EN/FALL_EN does not clear EVT bits that are already set.
- Reset (async, rst_i high):
  - OUT=OUT_RST, OE=OE_RST.
  - RISE_EN=FALL_EN=EVT=0; prescaler=0.
  - Sync flops, smp, IN and IN_d = 0.
  - rbus_rd_data_o=0, irq_o=0.
  - Reset mid-debounce discards the pending sample. After release, no event fires for pins already low. A pin held high produces a rise event after sync + debounce latency if RISE_EN is set.
- Unselected addresses: no state change, read data 0.

Test Plan:
- Reset/defaults: assert rst_i mid-operation with OUT=0xFF -> gpio_o=OUT_RST (0), gpio_oe_o=0, irq_o=0, rbus_rd_data_o=0 immediately (async).
- Set/clear: write OUT=0x0000_00F0, OUT_SET=0x0F, OUT_CLR=0x30 -> gpio_o reads 0xFF after the set, then 0xCF after the clear. Read of offset 1 returns 0xCF one cycle after rd.
- Read latency/decode: read offset 4 at BASE_ADDR+4 with gpio_i=0xA5 settled -> data 0xA5 appears exactly the cycle after rd. Read at BASE_ADDR+8 -> 0.
- Debounce (DB_TICK_W=2): pulse gpio_i[0] high for 3 clocks -> IN[0] stays 0. Hold high 16 clocks -> IN[0]=1 within SYNC_STAGES + 2 ticks (≤ 10 clocks).
- Events/irq: RISE_EN=0x1, FALL_EN=0x2, toggle bit0 up and bit1 down -> EVT=0x3 and irq_o=1 one cycle later. Write EVT=0x1 -> EVT=0x2, irq_o stays 1. Write EVT=0x2 -> irq_o=0 one cycle after EVT clears.
- Set-wins collision: W1C EVT bit0 in the same cycle a new rise on bit0 is detected -> EVT[0] remains 1 and irq_o remains 1.
